// File: rtl/calc_pkg.sv
// Shared constants and types for the calc 10-bit calculator controller.
package calc_pkg;
  localparam int CALC_W = 10;
  localparam int OP_W   = 5;

  localparam int OP_EQ  = 0;
  localparam int OP_ADD = 1;
  localparam int OP_SUB = 2;
  localparam int OP_MUL = 3;
  localparam int OP_DIV = 4;

  typedef enum logic [3:0] {
    ENTER1  = 4'd0,
    OP_HELD = 4'd1,
    ENTER2  = 4'd2,
    RESULT  = 4'd3
  } state_t;
endpackage

// File: rtl/calc_alu.sv
// Combinational calc ALU; the DIV branch exists only when CALC_DIV_EN is defined.
module calc_alu
  import calc_pkg::*;
(
  input  logic [CALC_W-1:0] a,
  input  logic [CALC_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [CALC_W-1:0] result
);
  always_comb begin
    result = a;
    case (op)
      5'b00010: result = a + b;
      5'b00100: result = a - b;
      5'b01000: result = a * b;
`ifdef CALC_DIV_EN
      5'b10000: result = (b == '0) ? '1 : a / b;
`endif
      default:  result = a;
    endcase
  end
endmodule

// File: rtl/calc.sv
// calc: operand/operator sequencing FSM for a 10-bit unsigned calculator.
// Define CALC_DIV_EN to enable the DIV operator on opcode[4].
module calc
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [OP_W-1:0]   opcode,
  input  logic [CALC_W-1:0] btn,
  output logic [3:0]        state,
  output logic [3:0]        nextstate,
  output logic [CALC_W-1:0] displayedNum,
  output logic [CALC_W-1:0] val1,
  output logic [CALC_W-1:0] val2,
  output logic [OP_W-1:0]   pressedOp,
  output logic [OP_W-1:0]   prevOp,
  output logic              op_pressed,
  output logic              btn_pressed
);
`ifdef CALC_DIV_EN
  localparam logic [OP_W-1:0] OP_MASK = 5'b11111;
`else
  localparam logic [OP_W-1:0] OP_MASK = 5'b01111;
`endif

  state_t            cur, nxt;
  logic [CALC_W-1:0] btn_q, alu_r;
  logic [OP_W-1:0]   op_q, op_in, win;
  logic              is_eq;

  assign op_in = opcode & OP_MASK;
  // isolate lowest set bit: EQ has highest priority
  assign win   = op_in & (~op_in + 5'd1);
  assign is_eq = win[OP_EQ];

  assign btn_pressed = !clr && (btn != btn_q);
  assign op_pressed  = !clr && (op_in != '0) && (op_q == '0);

  calc_alu u_alu (.a(val1), .b(val2), .op(prevOp), .result(alu_r));

  always_comb begin
    nxt = ENTER1;
    if (!clr) begin
      case (cur)
        ENTER1:  nxt = op_pressed ? (is_eq ? RESULT : OP_HELD) : ENTER1;
        OP_HELD: nxt = (op_in == '0) ? ENTER2 : OP_HELD;
        ENTER2:  nxt = op_pressed ? (is_eq ? RESULT : OP_HELD) : ENTER2;
        RESULT:  nxt = op_pressed ? (is_eq ? RESULT : OP_HELD)
                                  : (btn_pressed ? ENTER1 : RESULT);
        default: nxt = ENTER1;
      endcase
    end
  end

  assign state     = cur;
  assign nextstate = nxt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cur          <= ENTER1;
      btn_q        <= '0;
      op_q         <= '0;
      val1         <= '0;
      val2         <= '0;
      displayedNum <= '0;
      pressedOp    <= '0;
      prevOp       <= '0;
    end else begin
      btn_q <= btn;
      op_q  <= op_in;
      cur   <= nxt;
      // an operator press takes precedence; a simultaneous btn change is dropped
      case (cur)
        ENTER1: begin
          if (op_pressed) begin
            pressedOp    <= win;
            displayedNum <= val1;
            if (!is_eq) prevOp <= win;
          end else if (btn_pressed) begin
            val1         <= btn;
            displayedNum <= btn;
          end
        end
        ENTER2: begin
          if (op_pressed) begin
            pressedOp    <= win;
            val1         <= alu_r;
            displayedNum <= alu_r;
            prevOp       <= is_eq ? '0 : win;
          end else if (btn_pressed) begin
            val2         <= btn;
            displayedNum <= btn;
          end
        end
        RESULT: begin
          if (op_pressed) begin
            pressedOp <= win;
            if (!is_eq) prevOp <= win;
          end else if (btn_pressed) begin
            val1         <= btn;
            val2         <= '0;
            displayedNum <= btn;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_calc.sv
// Directed self-checking bench for calc with hand-computed expectations.
module tb_calc;
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] opcode = '0;
  logic [9:0] btn = '0;
  logic [3:0] state, nextstate;
  logic [9:0] displayedNum, val1, val2;
  logic [4:0] pressedOp, prevOp;
  logic       op_pressed, btn_pressed;

  int n_cmp = 0;
  int n_err = 0;

  calc dut (
    .clk(clk), .clr(clr), .opcode(opcode), .btn(btn),
    .state(state), .nextstate(nextstate), .displayedNum(displayedNum),
    .val1(val1), .val2(val2), .pressedOp(pressedOp), .prevOp(prevOp),
    .op_pressed(op_pressed), .btn_pressed(btn_pressed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drive inputs, then advance one edge and settle
  task automatic cyc(input logic [9:0] b, input logic [4:0] o);
    btn = b;
    opcode = o;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    cyc(10'd0, 5'd0);
    cyc(10'd0, 5'd0);
    clr = 1'b0;
  endtask

  // a OP b EQ, releasing each button after one cycle
  task automatic calc_run(input logic [9:0] a, input logic [4:0] o, input logic [9:0] b);
    do_reset();
    cyc(a, 5'd0);
    cyc(a, o);
    cyc(a, 5'd0);
    cyc(b, 5'd0);
    cyc(b, 5'b00001);
    cyc(b, 5'd0);
  endtask

  initial begin
    int pulses;

    // 1: reset with active inputs
    clr = 1'b1; btn = 10'd5; opcode = 5'd2;
    #1;
    chk("rst_op_strobe", op_pressed, 0);
    chk("rst_btn_strobe", btn_pressed, 0);
    cyc(10'd5, 5'd2);
    cyc(10'd5, 5'd2);
    chk("rst_state", state, 0);
    chk("rst_disp", displayedNum, 0);
    chk("rst_val1", val1, 0);
    chk("rst_val2", val2, 0);
    chk("rst_pressed", pressedOp, 0);
    chk("rst_prev", prevOp, 0);
    chk("rst_op_strobe2", op_pressed, 0);
    clr = 1'b0;
    cyc(10'd0, 5'd0);

    // 2: 6 ADD 3 EQ with intermediate operand edits
    cyc(10'd4, 5'd0);
    cyc(10'd4, 5'd0);
    cyc(10'd6, 5'd0);
    chk("t2_val1", val1, 6);
    btn = 10'd6; opcode = 5'b00010; #1;
    chk("t2_op_strobe", op_pressed, 1);
    cyc(10'd6, 5'b00010);
    chk("t2_state_held", state, 1);
    chk("t2_prev_add", prevOp, 5'b00010);
    btn = 10'd6; opcode = 5'd0; #1;
    chk("t2_next_enter2", nextstate, 2);
    cyc(10'd6, 5'd0);
    chk("t2_state_enter2", state, 2);
    cyc(10'd4, 5'd0);
    cyc(10'd0, 5'd0);
    cyc(10'd1, 5'd0);
    cyc(10'd3, 5'd0);
    chk("t2_val1_pre", val1, 6);
    chk("t2_val2", val2, 3);
    chk("t2_disp_b", displayedNum, 3);
    cyc(10'd3, 5'b00001);
    chk("t2_disp", displayedNum, 9);
    chk("t2_val1_res", val1, 9);
    chk("t2_prev_clr", prevOp, 0);
    chk("t2_state_res", state, 3);
    chk("t2_pressed", pressedOp, 5'b00001);
    // new operand from RESULT starts over
    cyc(10'd3, 5'd0);
    cyc(10'd12, 5'd0);
    chk("t2_restart_state", state, 0);
    chk("t2_restart_val1", val1, 12);
    chk("t2_restart_val2", val2, 0);

    // 3: wraparound arithmetic
    calc_run(10'd3, 5'b00100, 10'd5);
    chk("t3_sub_wrap", displayedNum, 1022);
    calc_run(10'd40, 5'b01000, 10'd30);
    chk("t3_mul_trunc", displayedNum, 176);

    // 4: chaining 7 ADD 2 SUB 4 EQ
    do_reset();
    cyc(10'd7, 5'd0);
    cyc(10'd7, 5'b00010);
    cyc(10'd7, 5'd0);
    cyc(10'd2, 5'd0);
    cyc(10'd2, 5'b00100);
    chk("t4_chain_disp", displayedNum, 9);
    chk("t4_chain_prev", prevOp, 5'b00100);
    chk("t4_chain_state", state, 1);
    cyc(10'd2, 5'd0);
    cyc(10'd4, 5'd0);
    cyc(10'd4, 5'b00001);
    chk("t4_final", displayedNum, 5);

    // 5: simultaneous buttons, single pulse while held, btn ignored in OP_HELD
    do_reset();
    cyc(10'd3, 5'd0);
    pulses = 0;
    btn = 10'd3; opcode = 5'b01010;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) btn = 10'd8;
      #1;
      if (op_pressed) pulses++;
      @(posedge clk);
      #1;
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_prev", prevOp, 5'b00010);
    chk("t5_pressed", pressedOp, 5'b00010);
    chk("t5_state_held", state, 1);
    chk("t5_val2_held", val2, 0);
    cyc(10'd8, 5'd0);
    chk("t5_state_enter2", state, 2);
    chk("t5_btn_consumed", btn_pressed, 0);
    chk("t5_val2_after", val2, 0);

    // 6: divide or masked opcode[4]
`ifdef CALC_DIV_EN
    calc_run(10'd9, 5'b10000, 10'd0);
    chk("t6_div0", displayedNum, 1023);
    calc_run(10'd9, 5'b10000, 10'd2);
    chk("t6_div", displayedNum, 4);
`else
    do_reset();
    cyc(10'd9, 5'd0);
    btn = 10'd9; opcode = 5'b10000; #1;
    chk("t6_masked_strobe", op_pressed, 0);
    cyc(10'd9, 5'b10000);
    chk("t6_masked_state", state, 0);
    chk("t6_masked_prev", prevOp, 0);
    chk("t6_masked_pressed", pressedOp, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/calc.md
Name: calc

Overview:
- Four-function (optionally five-function) 10-bit unsigned integer calculator controller.
- Operands arrive as a 10-bit binary value on `btn` (switch bank); operators arrive as a one-hot press on `opcode` (push-buttons).
- A small FSM sequences operand entry, operator hold/release and result display, and drives the number shown on the display.
- FSM state and internal registers are exported as outputs for debug and observation.

Parameters:
- None. Width is fixed at 10 bits via package constant `CALC_W = 10`.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge
- `clr`  input  1  reset, synchronous, active-high
- `opcode`  input  5  one-hot operator buttons: [0]=EQ, [1]=ADD, [2]=SUB, [3]=MUL, [4]=DIV
- `btn`  input  10  current operand value from switches
- `state`  output  4  registered FSM state
- `nextstate`  output  4  combinational next state
- `displayedNum`  output  10  registered value to display
- `val1`  output  10  accumulator / first operand
- `val2`  output  10  second operand
- `pressedOp`  output  5  one-hot of the last accepted operator press (including EQ)
- `prevOp`  output  5  pending arithmetic operator (0 = none)
- `op_pressed`  output  1  combinational press strobe
- `btn_pressed`  output  1  combinational operand-change strobe

Behaviour:
- Reset (`clr` high at a rising edge; overrides everything):
  - `state` = ENTER1.
  - `val1`, `val2`, `displayedNum`, `pressedOp`, `prevOp` = 0.
  - Internal `btn_q` and `op_q` = 0.
  - While `clr` is high, `op_pressed` and `btn_pressed` are forced to 0.
- Edge detection (registers `btn_q` and `op_q` load `btn`/`opcode` every cycle):
  - `btn_pressed` = (`btn` != `btn_q`).
  - `op_pressed` = (`opcode` != 0) && (`op_q` == 0).
- Accepted operator:
  - Lowest set bit of `opcode` wins: EQ > ADD > SUB > MUL > DIV.
  - On an accepted press, `pressedOp` loads the one-hot of the winning bit.
- States (encoding): ENTER1=0, OP_HELD=1, ENTER2=2, RESULT=3. Codes 4–15 are illegal and go to ENTER1 on the next edge with no other register change.
- ENTER1:
  - `btn_pressed` → `val1`<=`btn`, `displayedNum`<=`btn`.
  - Arithmetic op press → `prevOp`<=op, `displayedNum`<=`val1`, go to OP_HELD.
  - EQ press → `displayedNum`<=`val1`, go to RESULT.
- OP_HELD:
  - Wait until `opcode`==0, then go to ENTER2; `val2` is unchanged.
  - `btn` changes during OP_HELD are ignored (`btn_q` still tracks them, so they are consumed).
- ENTER2:
  - `btn_pressed` → `val2`<=`btn`, `displayedNum`<=`btn`.
  - EQ press → R = ALU(`val1`, `val2`, `prevOp`); `val1`<=R, `displayedNum`<=R, `prevOp`<=0, go to RESULT.
  - Arithmetic op press (chaining) → `val1`<=R, `displayedNum`<=R, `prevOp`<=new op, go to OP_HELD.
- RESULT:
  - `btn_pressed` → start a new calculation: `val1`<=`btn`, `val2`<=0, `displayedNum`<=`btn`, go to ENTER1.
  - Arithmetic op press → `prevOp`<=op, go to OP_HELD (continues from the result).
  - EQ press → no change.
- Simultaneous `btn_pressed` and `op_pressed` in the same cycle: the operator is handled and the btn change is consumed.
- ALU arithmetic:
  - Unsigned, result truncated to 10 bits (wraps modulo 1024).
  - SUB wraps: 3−5 = 1022.
  - MUL keeps the low 10 bits of the product.
  - DIV truncates; divide-by-zero gives 10'h3FF.
  - `prevOp`==0 passes `val1` through unchanged.
- Latency:
  - A `btn`/`opcode` change sampled at rising edge N is reflected in `state`, `val*` and `displayedNum` immediately after edge N.
  - Strobes are visible during the cycle before edge N.

Optional Feature:
- `CALC_DIV_EN` defined: `opcode[4]` is DIV, as above.
- `CALC_DIV_EN` undefined:
  - `opcode[4]` is masked to 0 before edge detection, so it never produces a press.
  - No divider is synthesised.

Decomposition:
- Package `calc_pkg`:
  - `CALC_W` = 10.
  - State enum (4-bit) with the encodings above.
  - Opcode bit-index constants `OP_EQ`, `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`.
- Sub-module `calc_alu`: purely combinational (`a`, `b`, `op`) → `result`; contains the DIV branch under `CALC_DIV_EN`.

Test Plan:
1. `clr`=1 for 2 cycles with `btn`=5, `opcode`=2 → all outputs 0, `state`=0, no strobes.
2. `btn` 0→4, hold, →6; `opcode`=00010 held, release; `btn`=4, 0, 1, 3; `opcode`=00001 → `val1`=6, `val2`=3, `prevOp`=ADD then 0, `displayedNum`=9, `state`=RESULT, `pressedOp`=00001.
3. 3 SUB 5 EQ → `displayedNum`=1022; 40 MUL 30 EQ → 176 (1200 mod 1024).
4. Chaining: 7 ADD 2 SUB 4 EQ → `displayedNum` shows 9 at the SUB press, final 5.
5. `opcode`=01010 (ADD|MUL) from ENTER1 → `prevOp`=00010; holding `opcode` for 10 cycles gives exactly one `op_pressed` pulse; `btn` change while held leaves `val2` unchanged.
6. With `CALC_DIV_EN`: 9 DIV 0 EQ → 1023; 9 DIV 2 EQ → 4. Without it: `opcode`=10000 → no `op_pressed`, `state` unchanged.
